// File: rtl/link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | link_pkg: protocol characters and FSM state encoding for the link    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package link_pkg;

  // Protocol characters, shared with the receive-side comparator.
  localparam logic [7:0] CHAR_READY = 8'h52;
  localparam logic [7:0] CHAR_LOSE  = 8'h4C;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t SEND    = 3'd1;
  localparam state_t WAIT_TX = 3'd2;
  localparam state_t BEACON  = 3'd3;
  localparam state_t LINKED  = 3'd4;
  localparam state_t DONE    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/link_beacon_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | link_beacon_timer: beacon interval counter with registered expire    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module link_beacon_timer #(
  parameter int BEACON_PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic expire_o
);

  localparam int            CW   = $clog2(BEACON_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(BEACON_PERIOD - 1);

  logic [CW-1:0] count_q, count_d;
  logic          expire_q, expire_d;

  // Expire is aligned with the count: high exactly while count_q == LAST.
  always_comb begin
    count_d  = clr_i ? '0 : count_q + CW'(1);
    expire_d = !clr_i && (count_d == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule
`default_nettype wire

// File: rtl/link_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | link_controller: TX sequencer for 'R' beacons/ack and 'L' loss bytes |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module link_controller
  import link_pkg::*;
#(
  parameter int BEACON_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play_selected_i,
  input  logic       player_lost_i,
  input  logic       opponent_ready_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       link_up_o,
  output logic       lose_sent_o
);

  state_t     state_q, state_d;
  state_t     next_q, next_d;
  logic       lose_pend_q, lose_pend_d;
  logic       ack_q, ack_d;
  logic       tx_start_q, tx_start_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       link_up_q, link_up_d;
  logic       lose_sent_q, lose_sent_d;

  logic       lose_now;
  logic       issue;
  logic       expire;

  link_beacon_timer #(
    .BEACON_PERIOD (BEACON_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != BEACON),
    .expire_o (expire)
  );

  // A loss pulse arriving this cycle counts immediately, so it wins over
  // a coincident beacon expiry or an 'R' about to be issued.
  assign lose_now = lose_pend_q | (player_lost_i & (state_q != IDLE));
  assign issue    = (state_q == SEND) & play_selected_i & ~tx_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      next_q      <= IDLE;
      lose_pend_q <= 1'b0;
      ack_q       <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      link_up_q   <= 1'b0;
      lose_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      lose_pend_q <= lose_pend_d;
      ack_q       <= ack_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      link_up_q   <= link_up_d;
      lose_sent_q <= lose_sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (play_selected_i) state_d = SEND;
      SEND: begin
        if (!play_selected_i)  state_d = IDLE;
        else if (!tx_busy_i)   state_d = WAIT_TX;
      end
      // tx_start_q is high only on the first WAIT_TX cycle: the guard cycle.
      WAIT_TX: begin
        if (!tx_start_q && !tx_busy_i) begin
          if (!play_selected_i)                state_d = IDLE;
          else if (lose_now && next_q != DONE) state_d = SEND;
          else                                 state_d = next_q;
        end
      end
      BEACON: begin
        if (!play_selected_i)                           state_d = IDLE;
        else if (lose_now || opponent_ready_i || expire) state_d = SEND;
      end
      LINKED: begin
        if (!play_selected_i) state_d = IDLE;
        else if (lose_now)    state_d = SEND;
      end
      DONE:    if (!play_selected_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_start_d = issue;
    tx_data_d  = tx_data_q;
    next_d     = next_q;
    ack_d      = ack_q;
    if (issue) begin
      tx_data_d = lose_now ? CHAR_LOSE : CHAR_READY;
      next_d    = lose_now ? DONE : (ack_q ? LINKED : BEACON);
    end
    if (state_q == BEACON && opponent_ready_i) ack_d = 1'b1;
    lose_pend_d = lose_now & ~issue;
    if (state_d == IDLE) begin
      lose_pend_d = 1'b0;
      ack_d       = 1'b0;
    end
    link_up_d   = (state_d == LINKED) || (state_d == DONE);
    lose_sent_d = (state_d == DONE);
  end

  assign tx_start_o  = tx_start_q;
  assign tx_data_o   = tx_data_q;
  assign link_up_o   = link_up_q;
  assign lose_sent_o = lose_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_link_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_link_controller: directed bench, BEACON_PERIOD=16, 10-cycle UART  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_link_controller;

  logic       clk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0;
  logic       lost = 1'b0;
  logic       opp  = 1'b0;
  logic       busy = 1'b0;
  logic       tx_start, link_up, lose_sent;
  logic [7:0] tx_data;

  int         n_pass   = 0;
  int         n_total  = 0;
  int         n_starts = 0;
  int         cyc      = 0;
  int         t_last   = 0;
  int         t_prev   = 0;
  int         busy_cnt = 0;
  logic [7:0] last_data = 8'h00;

  link_controller #(.BEACON_PERIOD(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .play_selected_i  (play),
    .player_lost_i    (lost),
    .opponent_ready_i (opp),
    .tx_busy_i        (busy),
    .tx_start_o       (tx_start),
    .tx_data_o        (tx_data),
    .link_up_o        (link_up),
    .lose_sent_o      (lose_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n0 = n_starts;
    int i  = 0;
    while (n_starts == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(n_starts != n0), 1);
  endtask

  // UART model: busy rises on the edge that samples tx_start, lasts 10 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      busy_cnt <= 0;
    end else if (busy) begin
      busy_cnt <= busy_cnt + 1;
      if (busy_cnt == 9) busy <= 1'b0;
    end else if (tx_start) begin
      busy     <= 1'b1;
      busy_cnt <= 0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      chk("start_while_busy", busy, 0);
      n_starts  <= n_starts + 1;
      t_prev    <= t_last;
      t_last    <= cyc;
      last_data <= tx_data;
    end
  end

  initial begin
    int n0;
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rst_tx_start",  tx_start,  0);
    chk("rst_tx_data",   tx_data,   8'h00);
    chk("rst_link_up",   link_up,   0);
    chk("rst_lose_sent", lose_sent, 0);

    // Reset while a byte is in flight.
    play = 1'b1;
    step(2);
    chk("pre_rst_start", tx_start, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_start", tx_start, 0);
    chk("async_rst_tx_data",  tx_data,  8'h00);
    chk("async_rst_link_up",  link_up,  0);
    play = 1'b0;
    n0 = n_starts;
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("post_rst_quiet", n_starts, n0);

    // Beaconing.
    play = 1'b1;
    step(1);
    chk("send_no_start_yet", tx_start, 0);
    step(1);
    chk("first_start", tx_start, 1);
    chk("first_data",  tx_data,  8'h52);
    wait_start("beacon1", 5);
    wait_start("beacon2", 40);
    chk("beacon_spacing1", t_last - t_prev, 29);
    wait_start("beacon3", 40);
    chk("beacon_spacing2", t_last - t_prev, 29);
    chk("beacon_link_up",  link_up,   0);
    chk("beacon_data",     last_data, 8'h52);

    // Handshake between beacons.
    step(15);
    opp = 1'b1;
    wait_start("ack", 10);
    chk("ack_data", last_data, 8'h52);
    for (int i = 0; i < 30 && !link_up; i++) @(negedge clk);
    chk("link_up", link_up, 1);
    n0 = n_starts;
    step(60);
    chk("linked_quiet",     n_starts,  n0);
    chk("linked_lose_sent", lose_sent, 0);

    // Loss while linked.
    lost = 1'b1;
    step(1);
    lost = 1'b0;
    chk("loss_send_state", tx_start, 0);
    step(1);
    chk("loss_start", tx_start, 1);
    chk("loss_data",  tx_data,  8'h4C);
    step(11);
    chk("loss_busy_fell",  busy,      0);
    chk("lose_sent_early", lose_sent, 0);
    step(1);
    chk("lose_sent",      lose_sent, 1);
    chk("done_link_up",   link_up,   1);
    step(5);
    chk("lose_sent_hold", lose_sent, 1);
    opp  = 1'b0;
    play = 1'b0;
    step(1);
    chk("exit_link_up",   link_up,   0);
    chk("exit_lose_sent", lose_sent, 0);

    // Loss coinciding with beacon expiry.
    step(2);
    n0 = n_starts;
    play = 1'b1;
    step(29);
    lost = 1'b1;
    step(1);
    lost = 1'b0;
    step(1);
    chk("prio_start", tx_start, 1);
    chk("prio_data",  tx_data,  8'h4C);
    chk("prio_count", n_starts, n0 + 1);
    for (int i = 0; i < 20 && !lose_sent; i++) @(negedge clk);
    chk("prio_lose_sent", lose_sent, 1);
    chk("prio_total",     n_starts,  n0 + 2);
    play = 1'b0;
    step(2);

    // Loss while the UART is busy.
    play = 1'b1;
    step(2);
    chk("busy_r_start", tx_start, 1);
    chk("busy_r_data",  tx_data,  8'h52);
    step(4);
    lost = 1'b1;
    step(1);
    lost = 1'b0;
    step(6);
    chk("busy_fell", busy, 0);
    step(1);
    chk("l_not_early", tx_start, 0);
    step(1);
    chk("l_two_after_busy", tx_start, 1);
    chk("l_data",           tx_data,  8'h4C);

    // Drop play during WAIT_TX: byte completes, then idle.
    play = 1'b0;
    n0 = n_starts;
    step(40);
    chk("abort_wait_count",     n_starts,  n0 + 1);
    chk("abort_wait_lose_sent", lose_sent, 0);
    chk("abort_wait_busy",      busy,      0);

    // Drop play during BEACON.
    play = 1'b1;
    step(2);
    chk("abort_b_start", tx_start, 1);
    step(15);
    play = 1'b0;
    n0 = n_starts;
    step(50);
    chk("abort_beacon_quiet", n_starts, n0);

    // Loss in IDLE is ignored: the next byte is 'R'.
    lost = 1'b1;
    step(1);
    lost = 1'b0;
    play = 1'b1;
    step(2);
    chk("restart_start",     tx_start, 1);
    chk("idle_loss_ignored", tx_data,  8'h52);
    play = 1'b0;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_controller.md
# link_controller

Transmit-side sequencer for the two-player UART link. Drives the UART transmitter with the protocol characters that the receive-side comparator decodes: 'R' (8'h52) as a ready beacon and 'L' (8'h4C) as a loss notification. It beacons 'R' until the opponent is ready, sends one acknowledge 'R', and then holds the link. It also arbitrates the single TX channel between beacon and loss traffic, with loss taking priority.

## Interface
- BEACON_PERIOD, 1_000_000: cycles between 'R' beacons while waiting for the opponent; legal range is ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- play_selected  in  1  level; local player is in the play screen.
- player_lost  in  1  one-cycle pulse; local player lost.
- opponent_ready  in  1  level from comparator; opponent 'R' received.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle request to send tx_data.
- tx_data  out  8  byte to send; valid while tx_start is high.
- link_up  out  1  handshake complete.
- lose_sent  out  1  'L' fully transmitted; held until game exit.

## Operation
- All outputs are registered. Reset value of every output is 0, including tx_data = 8'h00. State resets to IDLE, the counter to 0, and lose_pend to 0.
- lose_pend: set by player_lost in any state except IDLE. Cleared when 'L' is issued, and on return to IDLE.
- States:
  - IDLE: link_up = 0, lose_sent = 0. play_selected = 1 → SEND.
  - SEND: waits until tx_busy is sampled 0, then pulses tx_start.
    - If lose_pend = 1: tx_data = 8'h4C; after completion → DONE.
    - Otherwise: tx_data = 8'h52; after completion → BEACON, or → LINKED if the ack flag is set.
    - SEND → WAIT_TX on the tx_start edge.
  - WAIT_TX: one guard cycle in which tx_busy is ignored. Then waits for tx_busy = 0 and goes to the stored next state.
  - BEACON: counter clears on entry and increments each cycle.
    - opponent_ready = 1 → set ack flag, → SEND.
    - Counter reaches BEACON_PERIOD-1 → SEND (re-beacon).
    - lose_pend = 1 → SEND immediately.
  - LINKED: link_up = 1. lose_pend = 1 → SEND.
  - DONE: link_up = 1, lose_sent = 1. Held until play_selected = 0.
- play_selected = 0 returns the block to IDLE from any state except WAIT_TX. WAIT_TX always completes the byte first, then goes to IDLE.
- Simultaneous events:
  - player_lost with a beacon expiry: 'L' is sent, and no 'R' is sent.
  - opponent_ready with an expiry: a single ack 'R' is sent.
- player_lost while in IDLE is ignored.
- Deasserting rst_n mid-byte returns everything to reset values immediately. The UART completing a byte after that is not tracked.

## Timing
- play_selected first sampled 1 at edge k:
  - SEND is entered at k.
  - tx_start is high during cycle k+1..k+2, provided tx_busy = 0 at k+1.
- tx_start is high for exactly 1 cycle per byte. It is never asserted while tx_busy = 1, and never asserted twice within one WAIT_TX.
- Beacon spacing: with the UART idle, successive tx_start pulses are BEACON_PERIOD + 3 cycles apart plus the tx_busy duration.
- link_up rises on the edge that leaves WAIT_TX for LINKED after the ack byte.
- lose_sent rises on the edge that leaves WAIT_TX for DONE.
- Worst-case player_lost to 'L' start: completion of the in-flight byte plus 2 cycles.

## Structure
- Shared package link_pkg:
  - CHAR_READY = 8'h52 and CHAR_LOSE = 8'h4C, which the comparator also uses.
  - State encoding constants: IDLE, SEND, WAIT_TX, BEACON, LINKED, DONE.
- Sub-module link_beacon_timer:
  - Counter of width $clog2(BEACON_PERIOD).
  - Synchronous clear input; registered expire pulse.
- Top level holds the FSM, lose_pend, the ack flag, the next-state register and the output registers.

## Test plan
All tests use BEACON_PERIOD = 16 and a UART model whose busy time is 10 cycles.
- Reset: rst_n low mid-WAIT_TX → all outputs 0 within the same cycle; after release, IDLE with no tx_start.
- Beacon: play_selected = 1 and no opponent → 'R' pulses repeat at the required spacing; tx_data = 8'h52; link_up stays 0.
- Handshake: opponent_ready rises between beacons → exactly one extra 'R', then link_up = 1 and no further bytes.
- Loss: player_lost in LINKED → one 'L' (8'h4C); lose_sent = 1 after tx_busy falls; held until play_selected = 0, then both flags are 0.
- Priority: player_lost on the same cycle as beacon expiry → only 'L' is sent. player_lost while tx_busy = 1 → 'L' starts 2 cycles after tx_busy falls.
- Abort: play_selected drops during BEACON → IDLE next edge. Drops during WAIT_TX → the byte completes, then IDLE with no further tx_start.
